io_seg7_scan: RTL and testbench

- Time-multiplexed seven-segment display driver fed by one 32-bit I/O output port of the single-cycle computer, normally out_port0.
- Shows the port value as NDIG hex digits by scanning one digit at a time.
- Captures the port value once per scan frame, so a store landing mid-frame cannot tear the display.
- Sits between the I/O output register bank and the board's anode/segment pins.

---
 rtl/io_seg7_scan_pkg.sv | 20 ++
 rtl/io_seg7_scan_hex_to_seg7.sv | 17 +
 rtl/io_seg7_scan.sv | 131 +++++++++++++
 tb/tb_io_seg7_scan.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_seg7_scan_pkg.sv
// rtl/io_seg7_scan_pkg.sv - shared segment constants and hex decode table
package io_seg7_scan_pkg;

    // Segment bit positions within the 7-bit pattern
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G + 1;

    // Active-high g..a patterns, indexed by nibble value (entry 15 first)
    localparam logic [15:0][SEG_W-1:0] SEG7_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/io_seg7_scan_hex_to_seg7.sv
// rtl/io_seg7_scan_hex_to_seg7.sv - nibble to active-high seven-segment pattern
module hex_to_seg7
    import io_seg7_scan_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    logic [SEG_W-1:0] pat;

    assign pat = SEG7_HEX[nibble_i];

    // Explicit pin order so a board with different segment wiring only edits this line
    assign seg_o = {pat[SEG_G], pat[SEG_F], pat[SEG_E], pat[SEG_D],
                    pat[SEG_C], pat[SEG_B], pat[SEG_A]};

endmodule

// File: rtl/io_seg7_scan.sv
// rtl/io_seg7_scan.sv - time-multiplexed hex display driver with per-frame capture
module io_seg7_scan
    import io_seg7_scan_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             clrn,
    input  logic [31:0]      data_in,
    input  logic [NDIG-1:0]  dp_in,
    input  logic             en,
    input  logic             blank_lz,
    output logic [NDIG-1:0]  an,
    output logic [SEG_W-1:0] seg,
    output logic             dp,
    output logic             frame_tick
);

    localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_OFF   = {NDIG{ACTIVE_LOW}};
    localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ACTIVE_LOW}};
    localparam logic            DP_OFF   = ACTIVE_LOW;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [NDIG-1:0]  shadow_dp_q, shadow_dp_d;
    logic             blank_q, blank_d;
    logic [NDIG-1:0]  an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             ft_q, ft_d;

    logic             tick;
    logic             frame_start;
    logic [2:0]       nxt;
    logic [31:0]      src_data;
    logic [NDIG-1:0]  src_dp;
    logic             src_blank;
    logic [3:0]       nibble;
    logic [2:0]       hi_idx;
    logic             digit_blank;
    logic [SEG_W-1:0] seg_hot;
    logic [NDIG-1:0]  an_hot;

    assign tick        = (cnt_q == CNT_MAX);
    assign nxt         = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    assign frame_start = tick && (nxt == 3'd0);

    // Digit 0 of a frame decodes the value being captured on the same edge
    assign src_data  = (nxt == 3'd0) ? data_in  : shadow_q;
    assign src_dp    = (nxt == 3'd0) ? dp_in    : shadow_dp_q;
    assign src_blank = (nxt == 3'd0) ? blank_lz : blank_q;
    assign nibble    = src_data[{nxt, 2'b00} +: 4];
    assign an_hot    = NDIG'(1) << nxt;

    hex_to_seg7 u_hex (
        .nibble_i (nibble),
        .seg_o    (seg_hot)
    );

    // Highest nonzero digit of the frame value; digits above it are leading zeros
    always_comb begin
        hi_idx = 3'd0;
        for (int k = 0; k < NDIG; k++) begin
            if (src_data[4*k +: 4] != 4'h0) begin
                hi_idx = 3'(k);
            end
        end
    end

    assign digit_blank = src_blank && (nxt > hi_idx);

    // Next-state: prescaler, scan index, frame capture and registered pin values
    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + CW'(1);
        idx_d       = tick ? nxt : idx_q;
        shadow_d    = frame_start ? data_in  : shadow_q;
        shadow_dp_d = frame_start ? dp_in    : shadow_dp_q;
        blank_d     = frame_start ? blank_lz : blank_q;
        ft_d        = frame_start;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;
        if (!en) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end else if (tick) begin
            an_d  = ACTIVE_LOW ? ~an_hot : an_hot;
            seg_d = digit_blank ? SEG_OFF
                                : (ACTIVE_LOW ? ~seg_hot : seg_hot);
            dp_d  = digit_blank ? DP_OFF : (src_dp[nxt] ^ ACTIVE_LOW);
        end
    end

    // State registers; reset parks the index on the last digit so the first tick starts a frame
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            cnt_q       <= '0;
            idx_q       <= IDX_LAST;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            blank_q     <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            ft_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            blank_q     <= blank_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            ft_q        <= ft_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_io_seg7_scan.sv
// tb/tb_io_seg7_scan.sv - randomized model-checked bench for io_seg7_scan
module tb_io_seg7_scan;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [7:0]  dp_in = 8'h0;
    logic        en = 1'b1;
    logic        blank_lz = 1'b0;

    logic [7:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, ft0, ft1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    io_seg7_scan #(.NDIG(8), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut0 (
        .clock(clk), .clrn(clrn), .data_in(data_in), .dp_in(dp_in), .en(en),
        .blank_lz(blank_lz), .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0)
    );

    io_seg7_scan #(.NDIG(8), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut1 (
        .clock(clk), .clrn(clrn), .data_in(data_in), .dp_in(dp_in), .en(en),
        .blank_lz(blank_lz), .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex_ah(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] v, input int k);
        return 4'(v >> (4 * k));
    endfunction

    function automatic logic [7:0] an_al(input int k);
        logic [7:0] t;
        t = 8'h01 << k;
        return ~t;
    endfunction

    function automatic logic [6:0] seg_al(input logic [3:0] v);
        return ~hex_ah(v);
    endfunction

    // Reference model: unit 0 divides by 4 low-true, unit 1 divides by 1 high-true
    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    int          m_n[2];
    logic [31:0] m_data[2];
    logic [7:0]  m_dpc[2];
    logic        m_blank[2];
    logic [7:0]  m_an[2];
    logic [6:0]  m_seg[2];
    logic        m_dp[2];
    logic        m_ft[2];

    task automatic model_off(input int u);
        m_an[u]  = (u == 0) ? 8'hFF : 8'h00;
        m_seg[u] = (u == 0) ? 7'h7F : 7'h00;
        m_dp[u]  = (u == 0);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_n[u] = 0; m_data[u] = 0; m_dpc[u] = 0; m_blank[u] = 0; m_ft[u] = 0;
            model_off(u);
        end
    endtask

    // Edge n after reset release is a tick when n is a multiple of the divider;
    // tick number t lights digit (t-1) mod 8, and digit 0 captures the inputs.
    task automatic model_step(input int u);
        int   d;
        bit   tk;
        bit   blanked;
        m_n[u]++;
        m_ft[u] = 0;
        tk = (m_n[u] % div_of(u)) == 0;
        d = 0;
        if (tk) begin
            d = ((m_n[u] / div_of(u)) - 1) % 8;
            if (d == 0) begin
                m_data[u] = data_in; m_dpc[u] = dp_in; m_blank[u] = blank_lz; m_ft[u] = 1;
            end
        end
        if (!en) begin
            model_off(u);
        end else if (tk) begin
            blanked = m_blank[u] && (d > 0) && ((m_data[u] >> (4 * d)) == 0);
            m_an[u]  = 8'h01 << d;
            m_seg[u] = blanked ? 7'h00 : hex_ah(nib(m_data[u], d));
            m_dp[u]  = blanked ? 1'b0 : m_dpc[u][d];
            if (u == 0) begin
                m_an[u] = ~m_an[u]; m_seg[u] = ~m_seg[u]; m_dp[u] = ~m_dp[u];
            end
        end
    endtask

    always @(posedge clk) if (clrn === 1'b1) begin model_step(0); model_step(1); end
    always @(negedge clrn) model_reset();

    // Every cycle: both DUTs against the model
    always @(negedge clk) begin
        chk("cycle_u0", {an0, seg0, dp0, ft0}, {m_an[0], m_seg[0], m_dp[0], m_ft[0]});
        chk("cycle_u1", {an1, seg1, dp1, ft1}, {m_an[1], m_seg[1], m_dp[1], m_ft[1]});
    end

    // which: 0 = ft0 high, 1 = ft1 high, 2 = an0 equals val
    task automatic wait_cond(input int which, input logic [7:0] val, input string nm);
        int  c;
        bit  hit;
        c = 0;
        hit = 0;
        while (!hit && c < 200) begin
            @(negedge clk);
            c++;
            hit = (which == 0) ? (ft0 == 1'b1) : (which == 1) ? (ft1 == 1'b1) : (an0 == val);
        end
        if (!hit) begin
            tests++; fails++;
            $display("FAIL %s: timeout waiting for condition", nm);
        end
    endtask

    task automatic scenario_first();
        logic [31:0] v;
        v = 32'h1234ABCD;
        data_in = v; dp_in = 8'h00; en = 1'b1; blank_lz = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_an", an0, 8'hFF);
            chk("idle_seg", seg0, 7'h7F);
            if (i == 0) begin
                chk("div1_an", an1, 8'h01);
                chk("div1_seg", seg1, 7'h5E);
                chk("div1_ft", ft1, 1'b1);
            end
        end
        @(negedge clk);
        chk("first_an", an0, 8'hFE);
        chk("first_seg", seg0, seg_al(4'hD));
        chk("first_ft", ft0, 1'b1);
        for (int k = 1; k < 8; k++) begin
            repeat (4) @(negedge clk);
            chk("walk_an", an0, an_al(k));
            chk("walk_seg", seg0, seg_al(nib(v, k)));
            if (k == 3) data_in = 32'h0;
        end
        repeat (4) @(negedge clk);
        chk("wrap_an", an0, 8'hFE);
        chk("wrap_seg", seg0, seg_al(4'h0));
        chk("wrap_ft", ft0, 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        scenario_first();

        // Leading-zero blanking
        @(negedge clk);
        data_in = 32'h00000050; blank_lz = 1'b1;
        wait_cond(0, 8'h00, "lz_frame");
        chk("lz_d0_seg", seg0, seg_al(4'h0));
        repeat (4) @(negedge clk);
        chk("lz_d1_an", an0, an_al(1));
        chk("lz_d1_seg", seg0, seg_al(4'h5));
        repeat (4) @(negedge clk);
        chk("lz_d2_an", an0, an_al(2));
        chk("lz_d2_seg", seg0, 7'h7F);
        chk("lz_d2_dp", dp0, 1'b1);
        data_in = 32'h0;
        wait_cond(0, 8'h00, "lz0_frame");
        chk("lz0_d0_seg", seg0, seg_al(4'h0));
        repeat (4) @(negedge clk);
        chk("lz0_d1_an", an0, an_al(1));
        chk("lz0_d1_seg", seg0, 7'h7F);

        // Decimal point and enable
        blank_lz = 1'b0; data_in = 32'h89ABCDEF; dp_in = 8'h02;
        wait_cond(0, 8'h00, "dp_frame");
        chk("dp_d0", dp0, 1'b1);
        repeat (4) @(negedge clk);
        chk("dp_d1", dp0, 1'b0);
        repeat (4) @(negedge clk);
        chk("dp_d2", dp0, 1'b1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_an", an0, 8'hFF);
        chk("en_seg", seg0, 7'h7F);
        chk("en_dp", dp0, 1'b1);
        chk("en_an1", an1, 8'h00);
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (12) @(negedge clk);

        // Digit 8 on the high-true, divide-by-1 unit
        data_in = 32'h00000008; dp_in = 8'h00;
        wait_cond(1, 8'h00, "d8_frame");
        chk("d8_an1", an1, 8'h01);
        chk("d8_seg1", seg1, 7'h7F);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                data_in  = $urandom;
                dp_in    = 8'($urandom);
                blank_lz = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) data_in = data_in >> (4 * $urandom_range(0, 7));
            end
            en = ($urandom_range(0, 9) != 0);
        end

        // Asynchronous reset between edges while digit 5 is lit
        en = 1'b1; blank_lz = 1'b0; data_in = 32'h76543210;
        wait_cond(2, an_al(5), "rst_digit5");
        @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("rst_an", an0, 8'hFF);
        chk("rst_seg", seg0, 7'h7F);
        chk("rst_dp", dp0, 1'b1);
        chk("rst_ft", ft0, 1'b0);
        chk("rst_an1", an1, 8'h00);
        chk("rst_seg1", seg1, 7'h00);
        repeat (2) @(negedge clk);
        scenario_first();
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
